// File: rtl/mouse_cursor_tracker.sv
// mouse_cursor_tracker
//
// Integrates decoded PS/2 mouse packets into an absolute cursor position
// clamped to a SCREEN_W x SCREEN_H window, and derives per-button press /
// release pulses. Two-stage pipeline: stage 1 captures and scales the
// packet, stage 2 accumulates into the registered cursor. One packet per
// clock is accepted.
//
// Parameters:
//   SCREEN_W    cursor X range 0..SCREEN_W-1 (2..1024)
//   SCREEN_H    cursor Y range 0..SCREEN_H-1 (2..1024)
//   SPEED_SHIFT delta gain of 2^SPEED_SHIFT (0..2)
//   INVERT_Y    1 negates mouse Y (PS/2 +Y is up, screen +Y is down)
//
// Ports:
//   clk           system clock
//   rst_n         synchronous active-low reset
//   mouse_x/y     signed 9-bit deltas, valid with packet_ready
//   buttons       {M,R,L} button levels, valid with packet_ready
//   packet_ready  one-cycle packet strobe
//   center        one-cycle recenter request (beats any packet)
//   cursor_x/y    absolute cursor position
//   btn_state     registered button levels
//   btn_press     one-cycle rising-edge pulses
//   btn_release   one-cycle falling-edge pulses
//   update        one-cycle pulse when the outputs above were refreshed
//   packet_count  accepted packets, wraps at 16 bits
module mouse_cursor_tracker #(
    parameter int SCREEN_W    = 640,
    parameter int SCREEN_H    = 480,
    parameter int SPEED_SHIFT = 0,
    parameter int INVERT_Y    = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [8:0]  mouse_x,
    input  logic [8:0]  mouse_y,
    input  logic [2:0]  buttons,
    input  logic        packet_ready,
    input  logic        center,
    output logic [9:0]  cursor_x,
    output logic [9:0]  cursor_y,
    output logic [2:0]  btn_state,
    output logic [2:0]  btn_press,
    output logic [2:0]  btn_release,
    output logic        update,
    output logic [15:0] packet_count
);

    localparam logic [9:0] X_MAX = 10'(SCREEN_W - 1);
    localparam logic [9:0] Y_MAX = 10'(SCREEN_H - 1);
    localparam logic [9:0] X_CTR = 10'(SCREEN_W / 2);
    localparam logic [9:0] Y_CTR = 10'(SCREEN_H / 2);
    localparam logic       NEG_Y = (INVERT_Y != 0);

    // Sign-extend to 12 bits before shifting so the gain cannot overflow;
    // the largest magnitude (-256 << 2 = -1024, negated = 1024) still fits.
    function automatic logic signed [11:0] scale_delta(input logic [8:0] d,
                                                       input logic       neg);
        logic signed [11:0] e;
        e = $signed({{3{d[8]}}, d}) <<< SPEED_SHIFT;
        return neg ? -e : e;
    endfunction

    // Saturate a 12-bit signed candidate position into 0..hi.
    function automatic logic [9:0] clamp_coord(input logic signed [11:0] s,
                                               input logic [9:0]         hi);
        if (s < 12'sd0)
            return 10'd0;
        else if (s > $signed({2'b00, hi}))
            return hi;
        else
            return s[9:0];
    endfunction

    logic               accept;
    logic               vld_p1;
    logic signed [11:0] dx_p1;
    logic signed [11:0] dy_p1;
    logic [2:0]         b_p1;
    logic signed [11:0] sx;
    logic signed [11:0] sy;
    logic [9:0]         x_next;
    logic [9:0]         y_next;

    // A recenter in the same cycle drops the incoming packet entirely.
    assign accept = packet_ready & ~center;

    // ---- stage 1: capture and scale the packet ----
    always_ff @(posedge clk) begin
        if (accept) begin
            dx_p1 <= scale_delta(mouse_x, 1'b0);
            dy_p1 <= scale_delta(mouse_y, NEG_Y);
            b_p1  <= buttons;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1       <= 1'b0;
            packet_count <= 16'd0;
        end else begin
            vld_p1 <= accept;
            if (accept)
                packet_count <= packet_count + 16'd1;
        end
    end

    // ---- stage 2: accumulate into the registered cursor ----
    // The cursor feeds back from its own register, so back-to-back packets
    // each build on the result of the one before.
    always_comb begin
        sx     = $signed({2'b00, cursor_x}) + dx_p1;
        sy     = $signed({2'b00, cursor_y}) + dy_p1;
        x_next = clamp_coord(sx, X_MAX);
        y_next = clamp_coord(sy, Y_MAX);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cursor_x    <= X_CTR;
            cursor_y    <= Y_CTR;
            btn_state   <= 3'b000;
            btn_press   <= 3'b000;
            btn_release <= 3'b000;
            update      <= 1'b0;
        end else if (center) begin
            // Any packet sitting in stage 1 is discarded here (vld_p1 is
            // cleared through accept); button levels are kept.
            cursor_x    <= X_CTR;
            cursor_y    <= Y_CTR;
            btn_press   <= 3'b000;
            btn_release <= 3'b000;
            update      <= 1'b1;
        end else if (vld_p1) begin
            cursor_x    <= x_next;
            cursor_y    <= y_next;
            btn_press   <= b_p1 & ~btn_state;
            btn_release <= ~b_p1 & btn_state;
            btn_state   <= b_p1;
            update      <= 1'b1;
        end else begin
            btn_press   <= 3'b000;
            btn_release <= 3'b000;
            update      <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mouse_cursor_tracker.sv
// Bench for mouse_cursor_tracker: two instances (gain 1 and gain 4) share
// stimulus; a transaction-level model tracks the expected cursor with plain
// integer arithmetic and is compared against both every checked cycle.
module tb_mouse_cursor_tracker;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [8:0]  mouse_x, mouse_y;
    logic [2:0]  buttons;
    logic        packet_ready, center;

    logic [9:0]  a_cx, a_cy, b_cx, b_cy;
    logic [2:0]  a_bs, a_bp, a_br, b_bs, b_bp, b_br;
    logic        a_upd, b_upd;
    logic [15:0] a_cnt, b_cnt;

    mouse_cursor_tracker #(.SCREEN_W(640), .SCREEN_H(480), .SPEED_SHIFT(0), .INVERT_Y(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .mouse_x(mouse_x), .mouse_y(mouse_y),
        .buttons(buttons), .packet_ready(packet_ready), .center(center),
        .cursor_x(a_cx), .cursor_y(a_cy), .btn_state(a_bs), .btn_press(a_bp),
        .btn_release(a_br), .update(a_upd), .packet_count(a_cnt));

    mouse_cursor_tracker #(.SCREEN_W(640), .SCREEN_H(480), .SPEED_SHIFT(2), .INVERT_Y(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .mouse_x(mouse_x), .mouse_y(mouse_y),
        .buttons(buttons), .packet_ready(packet_ready), .center(center),
        .cursor_x(b_cx), .cursor_y(b_cy), .btn_state(b_bs), .btn_press(b_bp),
        .btn_release(b_br), .update(b_upd), .packet_count(b_cnt));

    int checks = 0;
    int failures = 0;

    // Reference model state
    int       m_cx[2], m_cy[2];
    logic [2:0] m_bs, m_bp, m_br;
    logic     m_upd;
    int       m_cnt;
    bit       p_v;
    int       p_mx, p_my;
    logic [2:0] p_b;

    function automatic int gain(int i);
        return (i == 0) ? 1 : 4;
    endfunction

    function automatic int clampi(int v, int hi);
        if (v < 0) return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs present at the edge.
    task automatic model_edge();
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin m_cx[i] = 320; m_cy[i] = 240; end
            m_bs = 0; m_bp = 0; m_br = 0; m_upd = 0; m_cnt = 0; p_v = 0;
        end else if (center) begin
            for (int i = 0; i < 2; i++) begin m_cx[i] = 320; m_cy[i] = 240; end
            m_bp = 0; m_br = 0; m_upd = 1; p_v = 0;
        end else begin
            if (p_v) begin
                for (int i = 0; i < 2; i++) begin
                    m_cx[i] = clampi(m_cx[i] + p_mx * gain(i), 639);
                    m_cy[i] = clampi(m_cy[i] - p_my * gain(i), 479);
                end
                m_bp = p_b & ~m_bs;
                m_br = ~p_b & m_bs;
                m_bs = p_b;
                m_upd = 1;
            end else begin
                m_bp = 0; m_br = 0; m_upd = 0;
            end
            p_v = packet_ready;
            if (packet_ready) begin
                p_mx = int'($signed(mouse_x));
                p_my = int'($signed(mouse_y));
                p_b  = buttons;
                m_cnt = (m_cnt + 1) % 65536;
            end
        end
    endtask

    task automatic check_all();
        check("a_cursor_x", 16'(a_cx), 16'(m_cx[0]));
        check("a_cursor_y", 16'(a_cy), 16'(m_cy[0]));
        check("b_cursor_x", 16'(b_cx), 16'(m_cx[1]));
        check("b_cursor_y", 16'(b_cy), 16'(m_cy[1]));
        check("a_btn_state", 16'(a_bs), 16'(m_bs));
        check("a_btn_press", 16'(a_bp), 16'(m_bp));
        check("a_btn_release", 16'(a_br), 16'(m_br));
        check("b_btn_press", 16'(b_bp), 16'(m_bp));
        check("a_update", 16'(a_upd), 16'(m_upd));
        check("b_update", 16'(b_upd), 16'(m_upd));
        check("a_packet_count", a_cnt, 16'(m_cnt));
        check("b_packet_count", b_cnt, 16'(m_cnt));
    endtask

    task automatic step(input bit chk);
        @(posedge clk);
        model_edge();
        #1;
        if (chk) check_all();
    endtask

    // Strobe one packet, then scramble the inputs and let stage 2 complete.
    task automatic send(input int mx, input int my, input logic [2:0] b);
        mouse_x = 9'(mx); mouse_y = 9'(my); buttons = b; packet_ready = 1'b1;
        step(1);
        packet_ready = 1'b0;
        mouse_x = 9'($urandom); mouse_y = 9'($urandom); buttons = 3'($urandom);
        step(1);
    endtask

    task automatic do_center();
        center = 1'b1; step(1); center = 1'b0; step(1);
    endtask

    initial begin
        rst_n = 1'b0; mouse_x = 0; mouse_y = 0; buttons = 0;
        packet_ready = 1'b0; center = 1'b0;
        step(1); step(1);
        check("rst_cursor_x", 16'(a_cx), 16'd320);
        check("rst_cursor_y", 16'(a_cy), 16'd240);
        check("rst_count", a_cnt, 16'd0);
        rst_n = 1'b1;
        step(1);

        // First packet and button edges
        send(5, 5, 3'b000);
        check("p1_x", 16'(a_cx), 16'd325);
        check("p1_y", 16'(a_cy), 16'd235);
        check("p1_update", 16'(a_upd), 16'd1);
        step(1);
        check("p1_update_drop", 16'(a_upd), 16'd0);
        send(10, 10, 3'b001);
        check("p2_press", 16'(a_bp), 16'b001);
        send(15, 15, 3'b010);
        check("p3_press", 16'(a_bp), 16'b010);
        check("p3_release", 16'(a_br), 16'b001);
        send(-7, -7, 3'b111);
        check("p4_press", 16'(a_bp), 16'b101);
        check("p4_x", 16'(a_cx), 16'd343);
        check("p4_y", 16'(a_cy), 16'd217);
        step(1);

        // Clamping
        do_center();
        send(-256, -256, 3'b000);
        send(-256, -256, 3'b000);
        check("clamp_a_x", 16'(a_cx), 16'd0);
        check("clamp_a_y", 16'(a_cy), 16'd479);
        send(255, 255, 3'b000);
        check("clamp_b_x", 16'(b_cx), 16'd639);
        check("clamp_b_y", 16'(b_cy), 16'd0);
        step(1);

        // Back-to-back
        do_center();
        mouse_x = 9'd1; mouse_y = 9'd0; buttons = 0; packet_ready = 1'b1;
        step(1); step(1); step(1);
        packet_ready = 1'b0;
        step(1);
        check("b2b_x3", 16'(a_cx), 16'd323);
        step(1); step(1);

        // Recenter colliding with a strobe
        mouse_x = 9'd50; mouse_y = 9'd50; packet_ready = 1'b1; center = 1'b1;
        step(1);
        packet_ready = 1'b0; center = 1'b0;
        step(1); step(1);
        check("coll_x", 16'(a_cx), 16'd320);
        // Recenter while a packet sits in stage 1
        mouse_x = 9'd30; packet_ready = 1'b1;
        step(1);
        packet_ready = 1'b0; center = 1'b1;
        step(1);
        center = 1'b0;
        step(1); step(1);
        check("stage1_drop_x", 16'(a_cx), 16'd320);

        // Reset mid-pipeline
        mouse_x = 9'd20; mouse_y = 9'd20; packet_ready = 1'b1;
        step(1);
        packet_ready = 1'b0; rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        step(1); step(1);
        check("midrst_count", a_cnt, 16'd0);
        check("midrst_update", 16'(a_upd), 16'd0);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            mouse_x      = 9'($urandom);
            mouse_y      = 9'($urandom);
            buttons      = 3'($urandom);
            packet_ready = ($urandom_range(0, 9) < 6);
            center       = ($urandom_range(0, 19) == 0);
            rst_n        = ($urandom_range(0, 99) != 0);
            step(1);
        end
        packet_ready = 1'b0; center = 1'b0; rst_n = 1'b1;
        step(1); step(1);

        // Packet counter wrap
        rst_n = 1'b0; step(1); rst_n = 1'b1;
        mouse_x = 0; mouse_y = 0; buttons = 0; packet_ready = 1'b1;
        for (int n = 0; n < 65535; n++) step(0);
        check("count_max", a_cnt, 16'hFFFF);
        step(1);
        check("count_wrap", a_cnt, 16'd0);
        packet_ready = 1'b0;
        step(1); step(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
